// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state encoding and default frame constants,
// used by both the transmit serializer and the UART receiver.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_SB_TICK    = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts one byte on transmit_begin and shifts it
// out LSB first as start / data / stop, paced by the oversampling tick s_tick.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int SB_TICK    = UART_SB_TICK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_tick,
  input  logic                 transmit_begin,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 transmit_active,
  output logic                 transmit_over
);

  localparam int TICK_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int TICK_W   = $clog2(TICK_MAX);
  localparam int BIT_W    = $clog2(DATA_BITS) + 1;

  localparam logic [TICK_W-1:0] OS_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] SB_LAST  = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

  uart_state_e          state_r, state_s;
  logic [TICK_W-1:0]    tick_r, tick_s;
  logic [BIT_W-1:0]     bit_r, bit_s;
  logic [DATA_BITS-1:0] shreg_r, shreg_s;
  logic                 tx_r, tx_s;
  logic                 active_r, active_s;
  logic                 over_r, over_s;

`ifdef UART_TX_PARITY_EN
  logic                 parity_r, parity_s;

  // Even parity of a byte: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    even_parity = ^d;
  endfunction
`endif

  // Next-state, counter, shifter and next-output logic for the frame FSM.
  always_comb begin
    state_s  = state_r;
    tick_s   = tick_r;
    bit_s    = bit_r;
    shreg_s  = shreg_r;
    tx_s     = tx_r;
    active_s = active_r;
    over_s   = over_r;
`ifdef UART_TX_PARITY_EN
    parity_s = parity_r;
`endif
    case (state_r)
      IDLE: begin
        tx_s = 1'b1;
        if (transmit_begin) begin
          shreg_s  = data_in;
          tick_s   = {TICK_W{1'b0}};
          bit_s    = {BIT_W{1'b0}};
          state_s  = START;
          tx_s     = 1'b0;
          active_s = 1'b1;
          over_s   = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_s = even_parity(data_in);
`endif
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_r == OS_LAST) begin
            tick_s  = {TICK_W{1'b0}};
            state_s = DATA;
            tx_s    = shreg_r[0];
          end else begin
            tick_s = tick_r + TICK_W'(1);
          end
        end else begin
          tick_s = tick_r;
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_r == OS_LAST) begin
            tick_s  = {TICK_W{1'b0}};
            shreg_s = {1'b0, shreg_r[DATA_BITS-1:1]};
            if (bit_r == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_s = PARITY;
              tx_s    = parity_r;
`else
              state_s = STOP;
              tx_s    = 1'b1;
`endif
            end else begin
              bit_s = bit_r + BIT_W'(1);
              tx_s  = shreg_r[1];
            end
          end else begin
            tick_s = tick_r + TICK_W'(1);
          end
        end else begin
          tick_s = tick_r;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (tick_r == OS_LAST) begin
            tick_s  = {TICK_W{1'b0}};
            state_s = STOP;
            tx_s    = 1'b1;
          end else begin
            tick_s = tick_r + TICK_W'(1);
          end
        end else begin
          tick_s = tick_r;
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (tick_r == SB_LAST) begin
            tick_s   = {TICK_W{1'b0}};
            state_s  = IDLE;
            tx_s     = 1'b1;
            active_s = 1'b0;
            over_s   = 1'b1;
          end else begin
            tick_s = tick_r + TICK_W'(1);
          end
        end else begin
          tick_s = tick_r;
        end
      end
      default: begin
        state_s  = IDLE;
        tick_s   = {TICK_W{1'b0}};
        bit_s    = {BIT_W{1'b0}};
        tx_s     = 1'b1;
        active_s = 1'b0;
      end
    endcase
  end

  // Frame registers; reset drops any partial frame and parks the line high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      tick_r   <= {TICK_W{1'b0}};
      bit_r    <= {BIT_W{1'b0}};
      shreg_r  <= {DATA_BITS{1'b0}};
      tx_r     <= 1'b1;
      active_r <= 1'b0;
      over_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      tick_r   <= tick_s;
      bit_r    <= bit_s;
      shreg_r  <= shreg_s;
      tx_r     <= tx_s;
      active_r <= active_s;
      over_r   <= over_s;
`ifdef UART_TX_PARITY_EN
      parity_r <= parity_s;
`endif
    end
  end

  assign tx              = tx_r;
  assign transmit_active = active_r;
  assign transmit_over   = over_r;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: a frame-level reference model
// checked every clock, plus literal bit sequences for hand-computed frames.
module tb_uart_tx_serializer;
  import uart_pkg::*;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam int SB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBITS    = 1 + DB + PB;       // bit slots before the stop bit
  localparam int FRAME    = NBITS * OS + SB;   // s_ticks from START back to IDLE
  localparam int TICK_DIV = 4;
  localparam int BUDGET   = FRAME * TICK_DIV + 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_tick = 1'b0;
  logic       transmit_begin = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx, transmit_active, transmit_over;

  int errors = 0;
  int checks = 0;

  // Reference model state: a frame is just "busy for FRAME s_ticks".
  logic       m_busy = 1'b0;
  logic       m_over = 1'b0;
  int         m_elapsed = 0;
  logic [7:0] m_data = 8'h00;

  // Monitor state
  int          act_ticks = 0;
  logic [15:0] cap = 16'h0000;
  int          gap_cnt = 0;
  int          last_gap = 0;
  int          rise_cnt = 0;
  logic        prev_active = 1'b0;

  uart_tx_serializer #(.DATA_BITS(DB), .OVERSAMPLE(OS), .SB_TICK(SB)) dut (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .transmit_begin(transmit_begin),
    .data_in(data_in), .tx(tx), .transmit_active(transmit_active),
    .transmit_over(transmit_over)
  );

  initial forever #5 clk = ~clk;

  // Reference model: counts accepted s_ticks since acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_over <= 1'b0; m_elapsed <= 0; m_data <= 8'h00;
    end else if (m_busy) begin
      if (s_tick) begin
        m_elapsed <= m_elapsed + 1;
        if (m_elapsed + 1 == FRAME) begin
          m_busy <= 1'b0; m_over <= 1'b1;
        end
      end
    end else if (transmit_begin) begin
      m_busy <= 1'b1; m_elapsed <= 0; m_over <= 1'b0; m_data <= data_in;
    end
  end

  // Expected line level: slot = elapsed ticks / OS over {start, data, parity, stop}.
  function automatic logic model_tx();
    int idx;
    if (!m_busy) return 1'b1;
    idx = m_elapsed / OS;
    if (idx == 0) return 1'b0;
    if (idx <= DB) return m_data[idx-1];
    if (idx < NBITS) return ^m_data;
    return 1'b1;
  endfunction

  // Monitor: counts s_ticks while active, captures tx mid-bit, measures gaps.
  always @(negedge clk) begin
    #2;
    prev_active <= transmit_active;
    if (transmit_active) gap_cnt <= 0;
    else gap_cnt <= gap_cnt + 1;
    if (transmit_active && !prev_active) begin
      rise_cnt  <= rise_cnt + 1;
      last_gap  <= gap_cnt;
      cap       <= 16'h0000;
      act_ticks <= s_tick ? 1 : 0;
    end else if (transmit_active && s_tick) begin
      if (act_ticks % OS == OS / 2) cap[act_ticks / OS] <= tx;
      act_ticks <= act_ticks + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_active(input logic lvl, input int budget, input string name);
    int n;
    n = 0;
    while (transmit_active !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(transmit_active), 32'(lvl));
  endtask

  task automatic pulse_frame(input logic [7:0] d);
    @(negedge clk);
    data_in = d;
    transmit_begin = 1'b1;
    @(negedge clk);
    transmit_begin = 1'b0;
  endtask

  task automatic idle_clks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

`ifdef UART_TX_PARITY_EN
  localparam logic [15:0] EXP_A5 = 16'b00000_10101001010;
  localparam logic [15:0] EXP_3C = 16'b00000_10001111000;
  localparam logic [15:0] EXP_FF = 16'b00000_10111111110;
  localparam int          EXP_TICKS = 176;
`else
  localparam logic [15:0] EXP_A5 = 16'b000000_1101001010;
  localparam logic [15:0] EXP_3C = 16'b000000_1001111000;
  localparam logic [15:0] EXP_FF = 16'b000000_1111111110;
  localparam int          EXP_TICKS = 160;
`endif

  initial begin
    int rises0;
    int n;
    fork
      begin : tick_gen
        int cnt;
        cnt = 0;
        forever begin
          @(negedge clk);
          cnt++;
          s_tick = (cnt % TICK_DIV == 0);
        end
      end
      begin : compare
        forever begin
          @(negedge clk);
          check("tx", 32'(tx), 32'(model_tx()));
          check("active", 32'(transmit_active), 32'(m_busy));
          check("over", 32'(transmit_over), 32'(m_over));
        end
      end
    join_none

    // Reset held for 5 clocks, then idle with s_tick running
    idle_clks(5);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_active", 32'(transmit_active), 32'd0);
    check("rst_over", 32'(transmit_over), 32'd0);
    rst_n = 1'b1;
    idle_clks(100);
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_active", 32'(transmit_active), 32'd0);
    check("idle_over", 32'(transmit_over), 32'd0);

    // Basic frame, 8'hA5
    pulse_frame(8'hA5);
    wait_active(1'b1, 4, "a5_start");
    wait_active(1'b0, BUDGET, "a5_end");
    idle_clks(2);
    check("a5_bits", 32'(cap), 32'(EXP_A5));
    check("a5_ticks", 32'(act_ticks), 32'(EXP_TICKS));
    idle_clks(30);
    check("a5_over_held", 32'(transmit_over), 32'd1);

    // Handshake: begin held until active, data changed mid-frame
    rises0 = rise_cnt;
    @(negedge clk);
    data_in = 8'h3C;
    transmit_begin = 1'b1;
    wait_active(1'b1, 4, "hs_start");
    transmit_begin = 1'b0;
    check("hs_over_clr", 32'(transmit_over), 32'd0);
    idle_clks(100);
    data_in = 8'hFF;
    wait_active(1'b0, BUDGET, "hs_end");
    idle_clks(40);
    check("hs_bits", 32'(cap), 32'(EXP_3C));
    check("hs_once", 32'(rise_cnt - rises0), 32'd1);
    check("hs_over", 32'(transmit_over), 32'd1);

    // Back-to-back: begin held with 8'h00 then 8'hFF
    @(negedge clk);
    data_in = 8'h00;
    transmit_begin = 1'b1;
    wait_active(1'b1, 4, "b2b_start1");
    data_in = 8'hFF;
    wait_active(1'b0, BUDGET, "b2b_end1");
    wait_active(1'b1, 4, "b2b_start2");
    transmit_begin = 1'b0;
    idle_clks(2);
    check("b2b_gap", 32'(last_gap), 32'd1);
    wait_active(1'b0, BUDGET, "b2b_end2");
    idle_clks(2);
    check("b2b_bits", 32'(cap), 32'(EXP_FF));

    // Reset during data bit 3
    pulse_frame(8'h81);
    n = 0;
    while (act_ticks < 4 * OS + 8 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached", 32'(act_ticks >= 4 * OS + 8), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_active", 32'(transmit_active), 32'd0);
    check("mid_rst_over", 32'(transmit_over), 32'd0);
    idle_clks(3);
    rst_n = 1'b1;
    idle_clks(10);
    pulse_frame(8'h3C);
    wait_active(1'b0, BUDGET, "post_rst_end");
    idle_clks(2);
    check("post_rst_bits", 32'(cap), 32'(EXP_3C));
    check("post_rst_ticks", 32'(act_ticks), 32'(EXP_TICKS));

`ifdef UART_TX_PARITY_EN
    // Parity: 8'h07 (odd popcount) then 8'h03 (even popcount)
    pulse_frame(8'h07);
    wait_active(1'b0, BUDGET, "p07_end");
    idle_clks(2);
    check("p07_bits", 32'(cap), 32'(16'b00000_11000001110));
    check("p07_ticks", 32'(act_ticks), 32'd176);
    pulse_frame(8'h03);
    wait_active(1'b0, BUDGET, "p03_end");
    idle_clks(2);
    check("p03_bits", 32'(cap), 32'(16'b00000_10000000110));
`endif

    idle_clks(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
